// File: rtl/sdram_cmd_scheduler.sv
// Row-aware priority scheduler feeding the EasySDRAM command buffer.
// Define SDRAM_SCHED_AGING_EN to build per-port starvation counters.
module sdram_cmd_scheduler #(
  parameter int ADDR_W     = 25,
  parameter int DATA_W     = 16,
  parameter int COL_W      = 10,
  parameter int CMDB_DEPTH = 256,
  parameter int MAX_STALL  = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     p0_empty,
  input  logic                     pV_empty,
  input  logic                     pC_empty,
  input  logic [ADDR_W+DATA_W:0]   p0_cmd,
  input  logic [ADDR_W+DATA_W:0]   pV_cmd,
  input  logic [ADDR_W+DATA_W:0]   pC_cmd,
  input  logic                     p0_urgent,
  input  logic                     pV_urgent,
  input  logic                     pC_urgent,
  output logic                     p0_pop,
  output logic                     pV_pop,
  output logic                     pC_pop,
  input  logic [7:0]               cmdb_usedw,
  input  logic                     row_closed,
  output logic                     cmd_send,
  output logic [ADDR_W+DATA_W:0]   cmd_data,
  output logic [1:0]               grant_id
);

  localparam int CMD_W   = 1 + ADDR_W + DATA_W;
  localparam int WR_BIT  = ADDR_W + DATA_W;
  localparam int ROW_W   = ADDR_W - COL_W;
  localparam int ROW_LSB = DATA_W + COL_W;
  localparam logic [7:0] BLK_LVL = 8'(CMDB_DEPTH - 2);
  localparam logic [CMD_W-1:0] WR_MASK = {1'b1, {WR_BIT{1'b0}}};

  typedef enum logic [1:0] {
    G_P0   = 2'd0,
    G_PV   = 2'd1,
    G_PC   = 2'd2,
    G_NONE = 2'd3
  } grant_e;

  logic [ROW_W-1:0] present_row;
  logic             row_valid;
  logic             last_was_write;

  logic             e0, ev, ec;
  logic             w0;
  logic             hit0, hitv, hitc;
  logic             u0, uv, uc;
  logic             blocked;
  grant_e           win;
  logic [CMD_W-1:0] win_cmd;

  assign e0 = !p0_empty;
  assign ev = !pV_empty;
  assign ec = !pC_empty;
  assign w0 = p0_cmd[WR_BIT];

  assign hit0 = row_valid &&
    p0_cmd[WR_BIT-1:ROW_LSB] == present_row;
  assign hitv = row_valid &&
    pV_cmd[WR_BIT-1:ROW_LSB] == present_row;
  assign hitc = row_valid &&
    pC_cmd[WR_BIT-1:ROW_LSB] == present_row;

  // Two-entry margin absorbs the command still in the output register.
  assign blocked = cmdb_usedw >= BLK_LVL;

`ifdef SDRAM_SCHED_AGING_EN
  localparam logic [7:0] STALL_LIM =
    (MAX_STALL > 255) ? 8'd255 : 8'(MAX_STALL);

  logic [7:0] stall0, stallv, stallc;

  function automatic logic [7:0] stall_nxt(
    input logic [7:0] cur,
    input logic       busy,
    input logic       won,
    input logic       blk
  );
    if (!busy || won) return 8'd0;
    if (blk || cur == 8'hff) return cur;
    return cur + 8'd1;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall0 <= 8'd0;
      stallv <= 8'd0;
      stallc <= 8'd0;
    end else begin
      stall0 <= stall_nxt(stall0, e0, win == G_P0, blocked);
      stallv <= stall_nxt(stallv, ev, win == G_PV, blocked);
      stallc <= stall_nxt(stallc, ec, win == G_PC, blocked);
    end
  end

  assign u0 = p0_urgent || stall0 >= STALL_LIM;
  assign uv = pV_urgent || stallv >= STALL_LIM;
  assign uc = pC_urgent || stallc >= STALL_LIM;
`else
  assign u0 = p0_urgent;
  assign uv = pV_urgent;
  assign uc = pC_urgent;
`endif

  always_comb begin
    win = G_NONE;
    if (!blocked) begin
      priority case (1'b1)
        e0 && u0:                          win = G_P0;
        ev && uv:                          win = G_PV;
        ec && uc:                          win = G_PC;
        last_was_write && e0 && w0 && hit0: win = G_P0;
        last_was_write && ec && hitc:       win = G_PC;
        ev && hitv:                        win = G_PV;
        e0 && !w0 && hit0:                 win = G_P0;
        e0 && w0:                          win = G_P0;
        ec:                                win = G_PC;
        ev:                                win = G_PV;
        e0:                                win = G_P0;
        default:                           win = G_NONE;
      endcase
    end
  end

  // VGA traffic is always a read, camera traffic always a write.
  always_comb begin
    win_cmd = '0;
    unique case (win)
      G_P0:    win_cmd = p0_cmd;
      G_PV:    win_cmd = pV_cmd & ~WR_MASK;
      G_PC:    win_cmd = pC_cmd | WR_MASK;
      default: win_cmd = '0;
    endcase
  end

  assign p0_pop = rst_n && win == G_P0;
  assign pV_pop = rst_n && win == G_PV;
  assign pC_pop = rst_n && win == G_PC;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_send       <= 1'b0;
      cmd_data       <= '0;
      grant_id       <= G_NONE;
      present_row    <= '0;
      row_valid      <= 1'b0;
      last_was_write <= 1'b1;
    end else if (win != G_NONE) begin
      cmd_send       <= 1'b1;
      cmd_data       <= win_cmd;
      grant_id       <= win;
      present_row    <= win_cmd[WR_BIT-1:ROW_LSB];
      row_valid      <= 1'b1;
      last_was_write <= win_cmd[WR_BIT];
    end else begin
      cmd_send <= 1'b0;
      grant_id <= G_NONE;
      if (row_closed) row_valid <= 1'b0;
    end
  end

endmodule
